// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM encoding
// and a counter-width helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line (resets to idle-high) plus a falling-edge
// flag built from the synchronised line and a registered copy of it.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rs,
  output logic rs_fall
);

  logic meta_q, meta_d;
  logic rs_q, rs_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx_in;
    rs_d   = meta_q;
    prev_d = rs_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      rs_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      rs_q   <= rs_d;
      prev_q <= prev_d;
    end
  end

  assign rs      = rs_q;
  assign rs_fall = prev_q & ~rs_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: configurable data/parity/stop, false-start rejection;
// frame delivered one cycle after the last stop sample, dropped with an overrun pulse if one is still held.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  logic rs;
  logic rs_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .rs      (rs),
    .rs_fall (rs_fall)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic par_x;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    par_x   = (^shift_q) ^ rs;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rs_fall) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end

      // Re-check the start bit at its centre; a high line here was only a glitch.
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rs ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {rs, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end

      S_PARITY: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          perr_d  = (PARITY == PARITY_ODD) ? ~par_x : par_x;
          state_d = S_STOP;
        end
      end

      // Leave at the last stop-bit centre so the next start edge is never missed.
      S_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (!rs) begin
            ferr_d = 1'b1;
          end
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // A held frame is never overwritten; the newcomer is discarded instead.
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
